// File: rtl/soc_boot_seq.sv
// SoC boot sequencer: programs the PLL dividers, waits for lock, loads boot/hart
// registers, then enables clocks and releases resets through a simple memory port.
module soc_boot_seq #(
    parameter int NUM_CORE     = 4,
    parameter int XLEN         = 64,
    parameter int FB_DIV_WIDTH = 12,
    parameter int POLL_TIMEOUT = 1024
) (
    input  logic                                     clk_i,
    input  logic                                     srst_i,
    input  logic                                     start_i,
    input  logic [NUM_CORE-1:0][FB_DIV_WIDTH-1:0]    core_fb_div_i,
    input  logic [FB_DIV_WIDTH-1:0]                  ram_fb_div_i,
    input  logic [NUM_CORE-1:0][XLEN-1:0]            boot_addr_i,
    output logic                                     mem_we_o,
    output logic [11:0]                              mem_waddr_o,
    output logic [63:0]                              mem_wdata_o,
    output logic [7:0]                               mem_wstrb_o,
    input  logic [1:0]                               mem_wresp_i,
    output logic                                     mem_re_o,
    output logic [11:0]                              mem_raddr_o,
    input  logic [63:0]                              mem_rdata_i,
    input  logic [1:0]                               mem_rresp_i,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic                                     err_o,
    output logic [1:0]                               err_code_o
);

    localparam int IDX_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
    localparam int TMO_W = $clog2(POLL_TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_WR_RAM_DIV  = 4'd1,
        S_WR_CORE_DIV = 4'd2,
        S_POLL_CORE   = 4'd3,
        S_POLL_RAM    = 4'd4,
        S_WR_BOOT     = 4'd5,
        S_WR_HART     = 4'd6,
        S_WR_CLK_CORE = 4'd7,
        S_WR_CLK_RAM  = 4'd8,
        S_WR_RST_CORE = 4'd9,
        S_WR_RST_RAM  = 4'd10,
        S_DONE        = 4'd11,
        S_ERR         = 4'd12
    } state_t;

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [TMO_W-1:0]   tmo_r;

    state_t             state_s;
    logic [IDX_W-1:0]   idx_s;
    logic [TMO_W-1:0]   tmo_s;
    logic [TMO_W-1:0]   tmo_inc_s;
    logic [1:0]         code_s;
    logic               last_idx_s;
    logic               core_lock_s;
    logic               ram_lock_s;
    logic               timeout_s;
    logic               wr_fail_s;
    logic               rd_fail_s;
    logic               busy_s;
    logic               we_s;
    logic               re_s;
    logic [11:0]        waddr_s;
    logic [11:0]        raddr_s;
    logic [63:0]        wdata_s;
    logic [7:0]         wstrb_s;

    // Next-state decision from the access being presented now, then the access for that next state.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        tmo_s       = tmo_r;
        code_s      = err_code_o;
        last_idx_s  = (idx_r == IDX_W'(NUM_CORE - 1));
        core_lock_s = &mem_rdata_i[NUM_CORE-1:0];
        ram_lock_s  = mem_rdata_i[0];
        tmo_inc_s   = tmo_r + TMO_W'(1);
        timeout_s   = (tmo_inc_s == TMO_W'(POLL_TIMEOUT));
        wr_fail_s   = mem_we_o && (mem_wresp_i != 2'b00);
        rd_fail_s   = mem_re_o && (mem_rresp_i != 2'b00);

        case (state_r)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_s = S_WR_RAM_DIV;
                    idx_s   = '0;
                    tmo_s   = '0;
                    code_s  = 2'd0;
                end else begin
                    state_s = state_r;
                end
            end
            S_WR_RAM_DIV: begin
                state_s = S_WR_CORE_DIV;
                idx_s   = '0;
            end
            S_WR_CORE_DIV: begin
                if (last_idx_s) begin
                    state_s = S_POLL_CORE;
                    idx_s   = '0;
                    tmo_s   = '0;
                end else begin
                    idx_s   = idx_r + IDX_W'(1);
                end
            end
            S_POLL_CORE: begin
                tmo_s = tmo_inc_s;
                if (core_lock_s) begin
                    state_s = S_POLL_RAM;
                end else if (timeout_s) begin
                    state_s = S_ERR;
                    code_s  = 2'd3;
                end else begin
                    state_s = S_POLL_CORE;
                end
            end
            S_POLL_RAM: begin
                tmo_s = tmo_inc_s;
                if (ram_lock_s) begin
                    state_s = S_WR_BOOT;
                    idx_s   = '0;
                end else if (timeout_s) begin
                    state_s = S_ERR;
                    code_s  = 2'd3;
                end else begin
                    state_s = S_POLL_RAM;
                end
            end
            S_WR_BOOT: begin
                if (last_idx_s) begin
                    state_s = S_WR_HART;
                    idx_s   = '0;
                end else begin
                    idx_s   = idx_r + IDX_W'(1);
                end
            end
            S_WR_HART: begin
                if (last_idx_s) begin
                    state_s = S_WR_CLK_CORE;
                    idx_s   = '0;
                end else begin
                    idx_s   = idx_r + IDX_W'(1);
                end
            end
            S_WR_CLK_CORE: state_s = S_WR_CLK_RAM;
            S_WR_CLK_RAM:  state_s = S_WR_RST_CORE;
            S_WR_RST_CORE: state_s = S_WR_RST_RAM;
            S_WR_RST_RAM:  state_s = S_DONE;
            default:       state_s = S_IDLE;
        endcase

        // A bad response overrides everything, including a lock timeout in the same cycle.
        if (wr_fail_s) begin
            state_s = S_ERR;
            code_s  = 2'd1;
        end else if (rd_fail_s) begin
            state_s = S_ERR;
            code_s  = 2'd2;
        end else begin
            code_s  = code_s;
        end

        we_s    = 1'b0;
        re_s    = 1'b0;
        waddr_s = 12'h000;
        raddr_s = 12'h000;
        wdata_s = 64'h0;
        wstrb_s = 8'h00;
        busy_s  = 1'b1;
        case (state_s)
            S_WR_RAM_DIV: begin
                we_s    = 1'b1;
                waddr_s = 12'h600;
                wdata_s = 64'(ram_fb_div_i);
            end
            S_WR_CORE_DIV: begin
                we_s    = 1'b1;
                waddr_s = 12'h400 + 12'({idx_s, 3'b000});
                wdata_s = 64'(core_fb_div_i[idx_s]);
            end
            S_POLL_CORE: begin
                re_s    = 1'b1;
                raddr_s = 12'hE00;
            end
            S_POLL_RAM: begin
                re_s    = 1'b1;
                raddr_s = 12'hE08;
            end
            S_WR_BOOT: begin
                we_s    = 1'b1;
                waddr_s = 12'h000 + 12'({idx_s, 3'b000});
                wdata_s = 64'(boot_addr_i[idx_s]);
            end
            S_WR_HART: begin
                we_s    = 1'b1;
                waddr_s = 12'h200 + 12'({idx_s, 3'b000});
                wdata_s = 64'(idx_s);
            end
            S_WR_CLK_CORE: begin
                we_s    = 1'b1;
                waddr_s = 12'hE10;
                wdata_s = 64'({NUM_CORE{1'b1}});
            end
            S_WR_CLK_RAM: begin
                we_s    = 1'b1;
                waddr_s = 12'hE18;
                wdata_s = 64'h1;
            end
            S_WR_RST_CORE: begin
                we_s    = 1'b1;
                waddr_s = 12'hE20;
                wdata_s = 64'h0;
            end
            S_WR_RST_RAM: begin
                we_s    = 1'b1;
                waddr_s = 12'hE28;
                wdata_s = 64'h0;
            end
            default: begin
                busy_s  = 1'b0;
            end
        endcase
        wstrb_s = we_s ? 8'hFF : 8'h00;
    end

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_r     <= S_IDLE;
            idx_r       <= '0;
            tmo_r       <= '0;
            mem_we_o    <= 1'b0;
            mem_re_o    <= 1'b0;
            mem_waddr_o <= 12'h000;
            mem_raddr_o <= 12'h000;
            mem_wdata_o <= 64'h0;
            mem_wstrb_o <= 8'h00;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= 2'd0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            tmo_r       <= tmo_s;
            mem_we_o    <= we_s;
            mem_re_o    <= re_s;
            mem_waddr_o <= waddr_s;
            mem_raddr_o <= raddr_s;
            mem_wdata_o <= wdata_s;
            mem_wstrb_o <= wstrb_s;
            busy_o      <= busy_s;
            done_o      <= (state_s == S_DONE);
            err_o       <= (state_s == S_ERR);
            err_code_o  <= code_s;
        end
    end

endmodule

// File: tb/tb_soc_boot_seq.sv
// Self-checking bench for soc_boot_seq: a scoreboard of expected memory accesses
// plus per-scenario status checks.
module tb_soc_boot_seq;

    localparam int NC  = 4;
    localparam int XL  = 64;
    localparam int FBW = 12;
    localparam int PTO = 16;

    logic                    clk = 1'b0;
    logic                    srst_i;
    logic                    start_i;
    logic [NC-1:0][FBW-1:0]  core_fb_div_i;
    logic [FBW-1:0]          ram_fb_div_i;
    logic [NC-1:0][XL-1:0]   boot_addr_i;
    logic                    mem_we_o;
    logic [11:0]             mem_waddr_o;
    logic [63:0]             mem_wdata_o;
    logic [7:0]              mem_wstrb_o;
    logic [1:0]              mem_wresp_i;
    logic                    mem_re_o;
    logic [11:0]             mem_raddr_o;
    logic [63:0]             mem_rdata_i;
    logic [1:0]              mem_rresp_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;
    logic [1:0]              err_code_o;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [63:0] data;
    } acc_t;

    acc_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          lock_n = 1;
    logic        ram_lock = 1'b1;
    logic        wr_inj = 1'b0;
    logic [11:0] wr_inj_addr = 12'h000;
    logic        rd_inj = 1'b0;
    int          n_core_rd = 0;
    int          n_acc = 0;
    logic        saw_boot0 = 1'b0;
    logic        last_we = 1'b0;
    logic [11:0] last_waddr = 12'h000;

    always #5 clk = ~clk;

    soc_boot_seq #(
        .NUM_CORE(NC), .XLEN(XL), .FB_DIV_WIDTH(FBW), .POLL_TIMEOUT(PTO)
    ) dut (
        .clk_i(clk), .srst_i(srst_i), .start_i(start_i),
        .core_fb_div_i(core_fb_div_i), .ram_fb_div_i(ram_fb_div_i),
        .boot_addr_i(boot_addr_i),
        .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
        .mem_wstrb_o(mem_wstrb_o), .mem_wresp_i(mem_wresp_i),
        .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
        .mem_rresp_i(mem_rresp_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    // Memory responder: lock registers, with optional error injection.
    always_comb begin
        mem_rdata_i = 64'h0;
        mem_rresp_i = 2'b00;
        mem_wresp_i = 2'b00;
        if (mem_re_o && mem_raddr_o == 12'hE00) begin
            mem_rdata_i = (n_core_rd >= lock_n) ? 64'h0000_0000_0000_000F : 64'hFFFF_FFFF_FFFF_FFF7;
            mem_rresp_i = rd_inj ? 2'b10 : 2'b00;
        end else if (mem_re_o && mem_raddr_o == 12'hE08) begin
            mem_rdata_i = ram_lock ? 64'h1 : 64'hFFFF_FFFF_FFFF_FFFE;
        end else begin
            mem_rdata_i = 64'h0;
        end
        if (wr_inj && mem_we_o && mem_waddr_o == wr_inj_addr) mem_wresp_i = 2'b10;
    end

    task automatic push_wr(input logic [11:0] a, input logic [63:0] d);
        acc_t e;
        e.we = 1'b1; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_rd(input logic [11:0] a);
        acc_t e;
        e.we = 1'b0; e.addr = a; e.data = 64'h0;
        exp_q.push_back(e);
    endtask

    task automatic push_head();
        push_wr(12'h600, 64'(ram_fb_div_i));
        for (int n = 0; n < NC; n++) push_wr(12'h400 + 12'(8 * n), 64'(core_fb_div_i[n]));
    endtask

    task automatic push_tail();
        for (int n = 0; n < NC; n++) push_wr(12'(8 * n), boot_addr_i[n]);
        for (int n = 0; n < NC; n++) push_wr(12'h200 + 12'(8 * n), 64'(n));
        push_wr(12'hE10, 64'hF);
        push_wr(12'hE18, 64'h1);
        push_wr(12'hE20, 64'h0);
        push_wr(12'hE28, 64'h0);
    endtask

    task automatic new_inputs();
        ram_fb_div_i = FBW'($urandom);
        for (int n = 0; n < NC; n++) begin
            core_fb_div_i[n] = FBW'($urandom);
            boot_addr_i[n]   = {$urandom, $urandom};
        end
        n_core_rd = 0; n_acc = 0; saw_boot0 = 1'b0; last_we = 1'b0;
    endtask

    // One cycle: sample at the falling edge and pop/compare any access against the scoreboard.
    task automatic tick();
        acc_t e;
        logic ok;
        @(negedge clk);
        if (mem_we_o || mem_re_o) begin
            n_acc++;
            last_we = mem_we_o;
            last_waddr = mem_waddr_o;
            if (mem_re_o && mem_raddr_o == 12'hE00) n_core_rd++;
            if (mem_we_o && mem_waddr_o == 12'h000) saw_boot0 = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected we=%0b re=%0b waddr=%h raddr=%h required no access",
                         mem_we_o, mem_re_o, mem_waddr_o, mem_raddr_o);
            end else begin
                e = exp_q.pop_front();
                if (e.we) ok = mem_we_o && !mem_re_o && mem_waddr_o == e.addr &&
                               mem_wdata_o == e.data && mem_wstrb_o == 8'hFF;
                else      ok = mem_re_o && !mem_we_o && mem_raddr_o == e.addr;
                if (!ok) begin
                    errors++;
                    $display("FAIL sb_access got we=%0b re=%0b waddr=%h raddr=%h wdata=%h strb=%h required we=%0b addr=%h data=%h",
                             mem_we_o, mem_re_o, mem_waddr_o, mem_raddr_o, mem_wdata_o, mem_wstrb_o,
                             e.we, e.addr, e.data);
                end
            end
        end else begin
            last_we = 1'b0;
        end
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        srst_i = 1'b1;
        start_i = 1'b1;
        repeat (3) tick();
        checks++;
        if ({mem_we_o, mem_re_o, busy_o, done_o, err_o, err_code_o, mem_waddr_o,
             mem_raddr_o, mem_wdata_o, mem_wstrb_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got we=%0b re=%0b busy=%0b done=%0b err=%0b code=%0d required all 0",
                     mem_we_o, mem_re_o, busy_o, done_o, err_o, err_code_o);
        end
        srst_i = 1'b0;
        start_i = 1'b0;
        repeat (2) tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_with_srst got busy=%0b required 0", busy_o);
        end
    endtask

    task automatic test_nominal();
        new_inputs();
        lock_n = 1; ram_lock = 1'b1;
        push_head(); push_rd(12'hE00); push_rd(12'hE08); push_tail();
        pulse_start();
        for (int c = 2; c <= 19; c++) begin
            start_i = (c == 6) ? 1'b1 : 1'b0;
            tick();
        end
        start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL nominal_cycle19 got busy=%0b done=%0b required 1 0", busy_o, done_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL nominal_done_cycle20 got done=%0b busy=%0b err=%0b required 1 0 0", done_o, busy_o, err_o);
        end
        checks++;
        if (n_acc != 19 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL nominal_count got accesses=%0d left=%0d required 19 0", n_acc, exp_q.size());
        end
    endtask

    task automatic test_delayed_lock();
        new_inputs();
        lock_n = 10;
        push_head();
        repeat (10) push_rd(12'hE00);
        push_rd(12'hE08);
        push_tail();
        pulse_start();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_done got done=%0b required 0", done_o);
        end
        for (int i = 0; i < 100 && !(done_o || err_o); i++) tick();
        checks++;
        if (done_o !== 1'b1 || n_core_rd != 10 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL delayed_lock got done=%0b core_reads=%0d left=%0d required 1 10 0",
                     done_o, n_core_rd, exp_q.size());
        end
        lock_n = 1;
    endtask

    task automatic test_timeout();
        new_inputs();
        ram_lock = 1'b0;
        push_head(); push_rd(12'hE00);
        repeat (PTO - 1) push_rd(12'hE08);
        pulse_start();
        for (int i = 0; i < 100 && !(done_o || err_o); i++) tick();
        checks++;
        if (err_o !== 1'b1 || done_o !== 1'b0 || err_code_o !== 2'd3) begin
            errors++;
            $display("FAIL timeout_err got err=%0b done=%0b code=%0d required 1 0 3", err_o, done_o, err_code_o);
        end
        checks++;
        if (saw_boot0 !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL timeout_no_boot got boot_write=%0b left=%0d required 0 0", saw_boot0, exp_q.size());
        end
        ram_lock = 1'b1;
    endtask

    task automatic test_write_error();
        new_inputs();
        wr_inj = 1'b1; wr_inj_addr = 12'h408;
        push_wr(12'h600, 64'(ram_fb_div_i));
        push_wr(12'h400, 64'(core_fb_div_i[0]));
        push_wr(12'h408, 64'(core_fb_div_i[1]));
        pulse_start();
        checks++;
        if (err_o !== 1'b0 || err_code_o !== 2'd0) begin
            errors++;
            $display("FAIL start_clears_err got err=%0b code=%0d required 0 0", err_o, err_code_o);
        end
        for (int i = 0; i < 20 && !(last_we && last_waddr == 12'h408); i++) tick();
        tick();
        checks++;
        if (mem_we_o !== 1'b0 || mem_re_o !== 1'b0 || err_o !== 1'b1 || err_code_o !== 2'd1) begin
            errors++;
            $display("FAIL write_error got we=%0b re=%0b err=%0b code=%0d required 0 0 1 1",
                     mem_we_o, mem_re_o, err_o, err_code_o);
        end
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0 || n_acc != 3) begin
            errors++;
            $display("FAIL write_error_count got accesses=%0d left=%0d required 3 0", n_acc, exp_q.size());
        end
        wr_inj = 1'b0;
    endtask

    task automatic test_read_error();
        new_inputs();
        rd_inj = 1'b1;
        push_head(); push_rd(12'hE00);
        pulse_start();
        for (int i = 0; i < 50 && !(done_o || err_o); i++) tick();
        repeat (2) tick();
        checks++;
        if (err_o !== 1'b1 || err_code_o !== 2'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL read_error got err=%0b code=%0d left=%0d required 1 2 0", err_o, err_code_o, exp_q.size());
        end
        rd_inj = 1'b0;
    endtask

    task automatic test_reset_mid();
        new_inputs();
        push_head(); push_rd(12'hE00); push_rd(12'hE08);
        push_wr(12'h000, boot_addr_i[0]);
        push_wr(12'h008, boot_addr_i[1]);
        pulse_start();
        for (int i = 0; i < 50 && !(last_we && last_waddr == 12'h008); i++) tick();
        srst_i = 1'b1;
        tick();
        checks++;
        if ({mem_we_o, mem_re_o, busy_o, done_o, err_o, err_code_o, mem_waddr_o,
             mem_raddr_o, mem_wdata_o, mem_wstrb_o} !== '0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_mid got we=%0b re=%0b busy=%0b waddr=%h left=%0d required all 0",
                     mem_we_o, mem_re_o, busy_o, mem_waddr_o, exp_q.size());
        end
        tick();
        srst_i = 1'b0;
        tick();
        new_inputs();
        push_head(); push_rd(12'hE00); push_rd(12'hE08); push_tail();
        pulse_start();
        for (int i = 0; i < 100 && !(done_o || err_o); i++) tick();
        checks++;
        if (done_o !== 1'b1 || n_acc != 19 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_after_reset got done=%0b accesses=%0d left=%0d required 1 19 0",
                     done_o, n_acc, exp_q.size());
        end
    endtask

    initial begin
        srst_i = 1'b1;
        start_i = 1'b0;
        new_inputs();
        test_reset();
        test_nominal();
        test_delayed_lock();
        test_timeout();
        test_write_error();
        test_read_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_boot_seq.md
SOC_BOOT_SEQ -- requirements
Module: soc_boot_seq

Interface
REQ-001 The block SHALL have parameter NUM_CORE, default 4, giving the number of cores to bring up.
REQ-002 The block SHALL have parameter XLEN, default 64, giving the boot-address width.
REQ-003 The block SHALL have parameter FB_DIV_WIDTH, default 12, giving the PLL feedback-divider width.
REQ-004 The block SHALL have parameter POLL_TIMEOUT, default 1024, giving the maximum number of PLL-lock poll cycles.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 The block SHALL have port clk_i, input, width 1: clock, all logic on the rising edge.
REQ-007 The block SHALL have port srst_i, input, width 1: synchronous active-high reset.
REQ-008 The block SHALL have port start_i, input, width 1: starts the sequence when sampled high in IDLE, DONE or ERR.
REQ-009 The block SHALL have port core_fb_div_i, input, width NUM_CORE x FB_DIV_WIDTH: per-core PLL divider.
REQ-010 The block SHALL have port ram_fb_div_i, input, width FB_DIV_WIDTH: RAM PLL divider.
REQ-011 The block SHALL have port boot_addr_i, input, width NUM_CORE x XLEN: per-core boot address.
REQ-012 The block SHALL have port mem_we_o, output, width 1: write request.
REQ-013 The block SHALL have port mem_waddr_o, output, width 12: write byte address.
REQ-014 The block SHALL have port mem_wdata_o, output, width 8x8: write data.
REQ-015 The block SHALL have port mem_wstrb_o, output, width 8: byte strobes.
REQ-016 The block SHALL have port mem_wresp_i, input, width 2: write response, valid in the same cycle as the request; 0 means OK.
REQ-017 The block SHALL have port mem_re_o, output, width 1: read request.
REQ-018 The block SHALL have port mem_raddr_o, output, width 12: read byte address.
REQ-019 The block SHALL have port mem_rdata_i, input, width 8x8: read data, valid in the same cycle as the request.
REQ-020 The block SHALL have port mem_rresp_i, input, width 2: read response, valid in the same cycle as the request; 0 means OK.
REQ-021 The block SHALL have port busy_o, output, width 1: sequence in progress.
REQ-022 The block SHALL have port done_o, output, width 1: sequence completed successfully.
REQ-023 The block SHALL have port err_o, output, width 1: sequence aborted.
REQ-024 The block SHALL have port err_code_o, output, width 2: abort cause, where 0 is none, 1 is write response, 2 is read response and 3 is lock timeout.

Function
REQ-025 The block SHALL implement the state sequence IDLE -> WR_RAM_DIV -> WR_CORE_DIV -> POLL_CORE -> POLL_RAM -> WR_BOOT -> WR_HART -> WR_CLK_CORE -> WR_CLK_RAM -> WR_RST_CORE -> WR_RST_RAM -> DONE, plus an ERR state.
REQ-026 The block SHALL perform exactly one access per cycle in every non-IDLE, non-DONE, non-ERR state; mem_we_o and mem_re_o SHALL never both be high.
REQ-027 Every write SHALL drive mem_wstrb_o=8'hFF, and its data SHALL be zero-extended to 64 bits.
REQ-028 In WR_RAM_DIV the block SHALL write ram_fb_div_i to 0x600.
REQ-029 In WR_CORE_DIV the block SHALL write core_fb_div_i[n] to 0x400+8n for n=0..NUM_CORE-1, using an index counter that resets to 0 on entry to each per-core state.
REQ-030 In POLL_CORE the block SHALL read 0xE00 each cycle and advance when rdata[NUM_CORE-1:0] is all ones.
REQ-031 In POLL_RAM the block SHALL read 0xE08 each cycle and advance when rdata[0]=1.
REQ-032 The poll timeout counter SHALL clear on entry to POLL_CORE and increment on each poll cycle in both poll states; when it reaches POLL_TIMEOUT without the lock condition being met, the block SHALL go to ERR with code 3.
REQ-033 In WR_BOOT the block SHALL write boot_addr_i[n] to 0x000+8n.
REQ-034 In WR_HART the block SHALL write the value n to 0x200+8n.
REQ-035 In WR_CLK_CORE the block SHALL write a NUM_CORE-bit all-ones value to 0xE10.
REQ-036 In WR_CLK_RAM the block SHALL write 1 to 0xE18.
REQ-037 In WR_RST_CORE the block SHALL write 0 to 0xE20.
REQ-038 In WR_RST_RAM the block SHALL write 0 to 0xE28.
REQ-039 A nonzero mem_wresp_i in any write cycle SHALL send the block to ERR with code 1; no further accesses SHALL be issued.
REQ-040 A nonzero mem_rresp_i in any read cycle SHALL send the block to ERR with code 2; no further accesses SHALL be issued.
REQ-041 The first access SHALL occur in the cycle after start_i is sampled.
REQ-042 With immediate lock, the sequence SHALL take 3*NUM_CORE+7 access cycles (19 for NUM_CORE=4), and done_o SHALL rise in the cycle after the last access.
REQ-043 busy_o SHALL be 1 exactly in the access states.
REQ-044 done_o and err_o SHALL hold until the next accepted start_i, which SHALL clear them and err_code_o.
REQ-045 start_i SHALL be ignored while busy_o=1.
REQ-046 A start_i asserted in the same cycle as srst_i SHALL be ignored.

Reset
REQ-047 When srst_i is sampled high, the block SHALL enter IDLE regardless of its current state, including mid-sequence.
REQ-048 During reset, mem_we_o, mem_re_o, busy_o, done_o and err_o SHALL all be 0.
REQ-049 During reset, mem_waddr_o, mem_raddr_o, mem_wdata_o, mem_wstrb_o, err_code_o and the index and timeout counters SHALL all be 0.

Verification
REQ-050 The bench SHALL cover the nominal case: NUM_CORE=4, lock inputs already all ones, start pulse -> 19 accesses in the order of REQ-025, hart writes 0,1,2,3 at 0x200/0x208/0x210/0x218, and done_o=1 at cycle 20.
REQ-051 The bench SHALL cover delayed lock: core lock reaches 4'hF after 10 poll reads -> exactly 10 reads of 0xE00 before the block leaves POLL_CORE, then done_o=1.
REQ-052 The bench SHALL cover timeout: POLL_TIMEOUT=16 with 0xE08 returning 0 -> err_o=1, err_code_o=3, and no access to 0x000.
REQ-053 The bench SHALL cover a write error: mem_wresp_i=2'b10 on the write to 0x408 -> err_code_o=1, and mem_we_o=0 in the following cycle.
REQ-054 The bench SHALL cover a read error: mem_rresp_i=2'b10 on the first 0xE00 read -> err_code_o=2.
REQ-055 The bench SHALL cover reset mid-sequence: srst_i during WR_BOOT -> IDLE with all outputs 0, and a later start_i -> a full sequence beginning at 0x600.
